conv_mac_sequencer: RTL and testbench

- Sequences the convolution multiply/CSA datapath for one output pixel.
- Takes a latched pixel window and kernel, and steps a 5-lane multiplier bank through up to five phases (MU1..MU5), five products per phase.
- Accumulates the phase sums and returns one NBITS result with a start/done handshake.
- Sits between the line-buffer/window front end and the output writer.
- Supports 5x5 kernels (param25) and 3x3 kernels (param9 content, 9 lanes used).

---
 rtl/conv_mac_sequencer_pkg.sv | 18 +
 rtl/conv_mac_sequencer_csa.sv | 39 +++
 rtl/conv_mac_sequencer.sv | 132 +++++++++++++
 tb/tb_conv_mac_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_sequencer_pkg.sv
// Shared convolution types: operand width, window/kernel arrays, multiplier phases and sequencer states.
package packConv;
    localparam int NBITS  = 20;
    localparam int LANES  = 5;
    localparam int PRODW  = 2 * NBITS;
    localparam int ACCW   = 2 * NBITS + 5;
    localparam int PH_5X5 = 5;
    localparam int PH_3X3 = 2;

    typedef logic [NBITS-1:0] regC;
    typedef regC [24:0]       param25;
    typedef regC [4:0]        five_words;
    typedef logic [PRODW-1:0] prod_t;
    typedef prod_t [LANES-1:0] prod5_t;

    typedef enum logic [2:0] {MU1, MU2, MU3, MU4, MU5} mul_states;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} seq_states;
endpackage

// File: rtl/conv_mac_sequencer_csa.sv
// csa_sum5: combinational sum of five signed 2*NBITS products via three 3:2 stages and one adder.
module csa_sum5
    import packConv::*;
(
    input  prod5_t              ops_i,
    output logic [PRODW+2:0]    sum_o
);
    localparam int W = PRODW + 3;
    typedef logic [W-1:0] word_t;

    word_t x0, x1, x2, x3, x4;
    word_t s1, c1, s2, c2, s3, c3;

    function automatic word_t sext(input prod_t p);
        return {{3{p[PRODW-1]}}, p};
    endfunction

    function automatic word_t carry(input word_t a, input word_t b, input word_t c);
        word_t m;
        m = (a & b) | (a & c) | (b & c);
        return {m[W-2:0], 1'b0};
    endfunction

    // Three guard bits hold the five-way growth, so modular carries never corrupt the sum.
    assign x0 = sext(ops_i[0]);
    assign x1 = sext(ops_i[1]);
    assign x2 = sext(ops_i[2]);
    assign x3 = sext(ops_i[3]);
    assign x4 = sext(ops_i[4]);

    assign s1 = x0 ^ x1 ^ x2;
    assign c1 = carry(x0, x1, x2);
    assign s2 = s1 ^ c1 ^ x3;
    assign c2 = carry(s1, c1, x3);
    assign s3 = s2 ^ c2 ^ x4;
    assign c3 = carry(s2, c2, x4);

    assign sum_o = s3 + c3;
endmodule

// File: rtl/conv_mac_sequencer.sv
// Steps a 5-lane MAC through MU1..MU5 (5x5) or MU1..MU2 (3x3) and returns one NBITS pixel result.
// Build with CONV_SAT_EN for a saturating result and a sticky sat output.
module conv_mac_sequencer
    import packConv::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  param25           win,
    input  param25           kern,
    output logic             busy,
    output logic             done,
    output mul_states        phase,
    output logic [NBITS-1:0] result
`ifdef CONV_SAT_EN
    ,
    output logic             sat
`endif
);
    seq_states        state_q, state_d;
    mul_states        phase_q, phase_d;
    logic             mode_q, mode_d;
    param25           win_q, win_d, kern_q, kern_d;
    logic [ACCW-1:0]  acc_q, acc_d, acc_next;
    logic [NBITS-1:0] result_q, result_d, result_red;
    logic             last_phase;
    prod5_t           prods;
    logic [PRODW+2:0] psum;

    always_comb begin
        prods = '0;
        for (int j = 0; j < LANES; j++) begin
            logic [4:0] idx;
            idx = 5'(5 * int'(phase_q) + j);
            prods[j] = $signed(win_q[idx]) * $signed(kern_q[idx]);
            // Index 9 belongs to the unused part of a 3x3 window.
            if (!mode_q && phase_q == MU2 && j == LANES - 1)
                prods[j] = '0;
        end
    end

    csa_sum5 u_csa (
        .ops_i (prods),
        .sum_o (psum)
    );

    assign acc_next   = acc_q + {{2{psum[PRODW+2]}}, psum};
    assign last_phase = (int'(phase_q) == (mode_q ? PH_5X5 : PH_3X3) - 1);

`ifdef CONV_SAT_EN
    logic sat_q, sat_d, clip;
    assign clip       = !(&acc_next[ACCW-1:NBITS-1] || ~|acc_next[ACCW-1:NBITS-1]);
    assign result_red = !clip ? acc_next[NBITS-1:0] :
                        acc_next[ACCW-1] ? {1'b1, {(NBITS-1){1'b0}}} : {1'b0, {(NBITS-1){1'b1}}};
    assign sat        = sat_q;
`else
    assign result_red = acc_next[NBITS-1:0];
`endif

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        mode_d   = mode_q;
        win_d    = win_q;
        kern_d   = kern_q;
        acc_d    = acc_q;
        result_d = result_q;
`ifdef CONV_SAT_EN
        sat_d    = sat_q;
`endif
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RUN;
                phase_d = MU1;
                mode_d  = mode;
                win_d   = win;
                kern_d  = kern;
                acc_d   = '0;
`ifdef CONV_SAT_EN
                sat_d   = 1'b0;
`endif
            end
            S_RUN: begin
                acc_d = acc_next;
                if (last_phase) begin
                    state_d  = S_DONE;
                    phase_d  = MU1;
                    result_d = result_red;
`ifdef CONV_SAT_EN
                    sat_d    = clip;
`endif
                end else begin
                    phase_d = mul_states'(phase_q + 3'd1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            phase_q  <= MU1;
            mode_q   <= 1'b0;
            win_q    <= '0;
            kern_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
`ifdef CONV_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            win_q    <= win_d;
            kern_q   <= kern_d;
            acc_q    <= acc_d;
            result_q <= result_d;
`ifdef CONV_SAT_EN
            sat_q    <= sat_d;
`endif
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign phase  = phase_q;
    assign result = result_q;
endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Self-checking bench: directed jobs with literal results plus randomized traffic against a job-level model.
module tb_conv_mac_sequencer;
    import packConv::*;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             mode  = 1'b0;
    param25           win   = '0;
    param25           kern  = '0;
    logic             busy, done;
    mul_states        phase;
    logic [NBITS-1:0] result;
`ifdef CONV_SAT_EN
    logic             sat;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    conv_mac_sequencer dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .win    (win),
        .kern   (kern),
        .busy   (busy),
        .done   (done),
        .phase  (phase),
        .result (result)
`ifdef CONV_SAT_EN
        ,
        .sat    (sat)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a job is the dot product of its active taps, then wrap or clamp to NBITS.
    function automatic void eval_job(input param25 w, input param25 kr, input logic m,
                                     output logic [NBITS-1:0] r, output bit clip);
        longint s;
        longint hi;
        longint lo;
        s  = 0;
        hi = (longint'(1) <<< (NBITS - 1)) - 1;
        lo = -(longint'(1) <<< (NBITS - 1));
        for (int i = 0; i < (m ? 25 : 9); i++)
            s += longint'($signed(w[i])) * longint'($signed(kr[i]));
        clip = (s > hi) || (s < lo);
        r    = s[NBITS-1:0];
`ifdef CONV_SAT_EN
        if (s > hi) r = hi[NBITS-1:0];
        if (s < lo) r = lo[NBITS-1:0];
`endif
    endfunction

    // Job timeline: k counts cycles since acceptance; busy for 1..lat-1, done at lat, idle after.
    bit               active   = 1'b0;
    int               k        = 0;
    int               lat      = 0;
    logic [NBITS-1:0] pend_res = '0;
    logic [NBITS-1:0] exp_res  = '0;
    bit               pend_sat = 1'b0;
    bit               exp_sat  = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            active  = 1'b0;
            k       = 0;
            exp_res = '0;
            exp_sat = 1'b0;
        end else begin
            if ((!active || k >= lat + 1) && start) begin
                active  = 1'b1;
                k       = 1;
                lat     = mode ? PH_5X5 + 1 : PH_3X3 + 1;
                eval_job(win, kern, mode, pend_res, pend_sat);
                exp_sat = 1'b0;
            end else if (active) begin
                k++;
            end
            if (active && k == lat) begin
                exp_res = pend_res;
                exp_sat = pend_sat;
            end
        end
    end

    always @(negedge clock) begin
        bit eb, ed;
        eb = active && k >= 1 && k <= lat - 1;
        ed = active && k == lat;
        chk("busy", 64'(busy), 64'(eb));
        chk("done", 64'(done), 64'(ed));
        chk("result", 64'(result), 64'(exp_res));
        if (eb) chk("phase", 64'(phase), 64'(k - 1));
`ifdef CONV_SAT_EN
        chk("sat", 64'(sat), 64'(exp_sat));
`endif
    end

    task automatic fill(input int wv, input int kv);
        for (int i = 0; i < 25; i++) begin
            win[i]  = regC'(wv);
            kern[i] = regC'(kv);
        end
    endtask

    task automatic go(input logic m);
        @(posedge clock); #1;
        mode  = m;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int exp_lat, input logic [NBITS-1:0] exp_r);
        int c;
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!done && c < 20);
        chk({nm, "_latency"}, 64'(c), 64'(exp_lat));
        chk({nm, "_result"}, 64'(result), 64'(exp_r));
    endtask

    task automatic run_job(input string nm, input logic m, input int exp_lat, input logic [NBITS-1:0] exp_r);
        go(m);
        wait_done(nm, exp_lat, exp_r);
        @(posedge clock); #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("reset_phase", 64'(phase), 64'(MU1));
        chk("reset_result", 64'(result), 64'd0);

        fill(1, 2);
        run_job("t1_5x5", 1'b1, 6, 20'd50);

        fill(1000, 1);
        for (int i = 0; i < 9; i++) win[i] = regC'(i + 1);
        run_job("t2_3x3", 1'b0, 3, 20'd45);

        fill(3, -1);
        run_job("t3_neg", 1'b0, 3, 20'hFFFE5);

        fill(1, 2);
        go(1'b1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("t5_phase_mu3", 64'(phase), 64'(MU3));
        reset = 1'b1;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        chk("t5_result", 64'(result), 64'd0);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        run_job("t5_after", 1'b1, 6, 20'd50);

        fill(1, 2);
        mode  = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        fill(1, 0);
        start = 1'b1;
        wait_done("t4_busy_start", 5, 20'd50);
        @(posedge clock); #1;
        start = 1'b0;
        chk("t4_idle_busy", 64'(busy), 64'd0);
        run_job("t4_next", 1'b1, 6, 20'd0);

        fill(1000, 1000);
`ifdef CONV_SAT_EN
        run_job("t6_ovf", 1'b1, 6, 20'h7FFFF);
        chk("t6_sat", 64'(sat), 64'd1);
`else
        run_job("t6_ovf", 1'b1, 6, 20'hD7840);
`endif

        for (int cyc = 0; cyc < 600; cyc++) begin
            bool_sel: begin
                bit wide;
                wide = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < 25; i++) begin
                    win[i]  = wide ? regC'($urandom) : regC'(int'($urandom_range(0, 16)) - 8);
                    kern[i] = wide ? regC'($urandom) : regC'(int'($urandom_range(0, 16)) - 8);
                end
            end
            mode  = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 2) == 0);
            @(posedge clock); #1;
        end
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
